// File: rtl/loop_seq_pkg.sv
// Shared definitions for the loop sequencer: state encoding, default widths and
// datapath mux-select constants.
package loop_seq_pkg;

    typedef logic [2:0] state_t;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_REP_W  = 4;

    localparam state_t S_IDLE      = 3'd0;
    localparam state_t S_INIT      = 3'd1;
    localparam state_t S_CHECK     = 3'd2;
    localparam state_t S_OUTPUT    = 3'd3;
    localparam state_t S_INCR      = 3'd4;
    localparam state_t S_NEXT_PASS = 3'd5;
    localparam state_t S_DONE      = 3'd6;

    localparam logic SEL_ZERO = 1'b0;
    localparam logic SEL_INC  = 1'b1;

endpackage

// File: rtl/loop_sequencer_pass_counter.sv
// Pass down-counter: loaded with the pass count at start, decremented once per
// completed pass; is_last flags the final pass (count == 1).
module pass_counter #(
    parameter int REP_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [REP_W-1:0] load_val,
    input  logic             dec,
    output logic             is_last
);

    logic [REP_W-1:0] count_q;
    logic [REP_W-1:0] count_d;

    // Count register with synchronous active-low clear.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q <= {REP_W{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    // Load takes priority over decrement.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (dec) begin
            count_d = count_q - REP_W'(1);
        end else begin
            count_d = count_q;
        end
    end

    assign is_last = (count_q == REP_W'(1));

endmodule

// File: rtl/loop_sequencer.sv
// Restartable multi-pass Moore controller for the A/Sum loop datapath.
// Optional build macro LOOP_SEQ_STEP_EN: OUTPUT holds until step=1.
module loop_sequencer
    import loop_seq_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int REP_W  = DEF_REP_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] limit,
    input  logic [REP_W-1:0]  passes,
    input  logic              a_lt_limit,
    input  logic              step,
    output logic [DATA_W-1:0] limit_q,
    output logic              a_src_sel,
    output logic              sum_src_sel,
    output logic              a_load,
    output logic              sum_load,
    output logic              out_port,
    output logic              busy,
    output logic              done
);

    state_t            state_q;
    state_t            state_d;
    logic [DATA_W-1:0] limit_d;
    logic              accept_s;
    logic              is_last_s;
    logic              sum_first_s;

    assign accept_s = (state_q == S_IDLE) && start;

    pass_counter #(.REP_W(REP_W)) u_pass_counter (
        .clk      (clk),
        .reset    (reset),
        .load     (accept_s),
        .load_val (passes),
        .dec      (state_q == S_NEXT_PASS),
        .is_last  (is_last_s)
    );

`ifdef LOOP_SEQ_STEP_EN
    logic out_held_q;

    // Remembers that OUTPUT was already active last cycle, so Sum is added once.
    always_ff @(posedge clk) begin
        if (!reset) begin
            out_held_q <= 1'b0;
        end else begin
            out_held_q <= (state_q == S_OUTPUT);
        end
    end

    assign sum_first_s = !out_held_q;
`else
    logic unused_step_s;
    assign unused_step_s = step;
    assign sum_first_s   = 1'b1;
`endif

    // State and latched-limit registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            limit_q <= {DATA_W{1'b0}};
        end else begin
            state_q <= state_d;
            limit_q <= limit_d;
        end
    end

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        limit_d = accept_s ? limit : limit_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = (passes == {REP_W{1'b0}}) ? S_DONE : S_INIT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_INIT:      state_d = S_CHECK;
            S_CHECK:     state_d = a_lt_limit ? S_OUTPUT : S_NEXT_PASS;
`ifdef LOOP_SEQ_STEP_EN
            S_OUTPUT:    state_d = step ? S_INCR : S_OUTPUT;
`else
            S_OUTPUT:    state_d = S_INCR;
`endif
            S_INCR:      state_d = S_CHECK;
            S_NEXT_PASS: state_d = is_last_s ? S_DONE : S_INIT;
            S_DONE:      state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    // Moore output decode from the registered state.
    always_comb begin
        a_src_sel   = SEL_ZERO;
        sum_src_sel = SEL_ZERO;
        a_load      = 1'b0;
        sum_load    = 1'b0;
        out_port    = 1'b0;
        done        = 1'b0;
        busy        = (state_q != S_IDLE);
        case (state_q)
            S_INIT: begin
                a_load   = 1'b1;
                sum_load = 1'b1;
            end
            S_OUTPUT: begin
                out_port    = 1'b1;
                sum_src_sel = SEL_INC;
                sum_load    = sum_first_s;
            end
            S_INCR: begin
                a_src_sel = SEL_INC;
                a_load    = 1'b1;
            end
            S_DONE:  done = 1'b1;
            default: done = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_loop_sequencer.sv
// Self-checking bench for loop_sequencer with a behavioural A/Sum datapath and
// closed-form expectations for latency, pulse counts and final Sum.
module tb_loop_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] limit;
    logic [3:0] passes;
    logic       a_lt_limit;
    logic       step;
    logic [7:0] limit_q;
    logic       a_src_sel, sum_src_sel, a_load, sum_load, out_port, busy, done;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [7:0] dp_a   = 8'd0;
    logic [7:0] dp_sum = 8'd0;

    always #5 clk = ~clk;

    loop_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .limit       (limit),
        .passes      (passes),
        .a_lt_limit  (a_lt_limit),
        .step        (step),
        .limit_q     (limit_q),
        .a_src_sel   (a_src_sel),
        .sum_src_sel (sum_src_sel),
        .a_load      (a_load),
        .sum_load    (sum_load),
        .out_port    (out_port),
        .busy        (busy),
        .done        (done)
    );

    // Datapath the controller steers: A and Sum registers with their source muxes.
    always @(posedge clk) begin
        if (a_load)   dp_a   <= a_src_sel ? dp_a + 8'd1 : 8'd0;
        if (sum_load) dp_sum <= sum_src_sel ? dp_sum + dp_a : 8'd0;
    end
    assign a_lt_limit = (dp_a < limit_q);

    task automatic check(input string tag, input longint obs, input longint exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One run from IDLE: start is driven in cycle 0, outputs are sampled on negedges.
    task automatic run(input int L, input int P, input bit use_step, input bit poke);
        int done_cyc = -1;
        int pulses = 0, a_loads = 0, s_loads = 0, out_cyc = 0, busy_low = 0;
        int run_len = 0, bad_seq = 0, exp_done, budget;
        logic [7:0] sum_at_done = 8'd0, a_at_done = 8'd0;
        logic prev_out = 1'b0;
        int a_seen[$];
        int exp_seq[$];
        exp_done = (P == 0) ? 1 : 1 + P * (3 * L + 3) + (use_step ? P * L * 4 : 0);
        budget = exp_done + 30;
        @(negedge clk);
        start = 1'b1; limit = 8'(L); passes = 4'(P);
        for (int k = 1; k <= budget; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (!busy) busy_low++;
            if (a_load) a_loads++;
            if (sum_load) s_loads++;
            if (out_port) begin
                out_cyc++;
                run_len++;
                if (!prev_out) begin
                    pulses++;
                    a_seen.push_back(int'(dp_a));
                end
            end else begin
                run_len = 0;
            end
            prev_out = out_port;
            step = use_step ? (out_port && run_len == 5) : 1'($urandom_range(0, 1));
            if (poke && k == 3) begin
                start = 1'b1; limit = 8'(L + 5); passes = 4'(P + 1);
            end
            if (poke && k == 4) begin
                limit = 8'(L); passes = 4'(P);
            end
            if (done) begin
                done_cyc = k; sum_at_done = dp_sum; a_at_done = dp_a;
                break;
            end
        end
        step = 1'b0;
        for (int p = 0; p < P; p++)
            for (int i = 0; i < L; i++) exp_seq.push_back(i);
        for (int i = 0; i < a_seen.size() && i < exp_seq.size(); i++)
            if (a_seen[i] != exp_seq[i]) bad_seq++;
        check($sformatf("done_cycle L=%0d P=%0d", L, P), done_cyc, exp_done);
        check($sformatf("out_pulses L=%0d P=%0d", L, P), pulses, P * L);
        check($sformatf("out_cycles L=%0d P=%0d", L, P), out_cyc, P * L * (use_step ? 5 : 1));
        check($sformatf("a_loads L=%0d P=%0d", L, P), a_loads, P * (L + 1));
        check($sformatf("sum_loads L=%0d P=%0d", L, P), s_loads, P * (L + 1));
        check($sformatf("a_seq_bad L=%0d P=%0d", L, P), bad_seq, 0);
        check($sformatf("busy_low L=%0d P=%0d", L, P), busy_low, 0);
        check($sformatf("limit_q L=%0d P=%0d", L, P), limit_q, L);
        if (P > 0) begin
            check($sformatf("sum L=%0d P=%0d", L, P), sum_at_done, (L * (L - 1) / 2) & 255);
            check($sformatf("a_final L=%0d P=%0d", L, P), a_at_done, L);
        end
        @(negedge clk);
        check("done_one_cycle", done, 0);
        check("busy_after_done", busy, 0);
    endtask

    initial begin
        int L, P, waited;
        reset = 1'b0; start = 1'b0; step = 1'b0; limit = 8'd0; passes = 4'd0;
        @(negedge clk);
        @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_limit_q", limit_q, 0);
        reset = 1'b1;

        // Reset asserted while the loop sits in OUTPUT.
        @(negedge clk);
        start = 1'b1; limit = 8'd5; passes = 4'd1;
        @(negedge clk);
        start = 1'b0;
        waited = 0;
        while (!out_port && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        check("reach_output", out_port, 1);
        reset = 1'b0;
        @(negedge clk);
        check("rst_outputs", {a_src_sel, sum_src_sel, a_load, sum_load, out_port, busy, done}, 0);
        check("rst_limit_q", limit_q, 0);
        @(negedge clk);
        reset = 1'b1;
        run(3, 1, 1'b0, 1'b0);

        run(10, 1, 1'b0, 1'b0);
        run(4, 3, 1'b0, 1'b0);
        run(7, 0, 1'b0, 1'b0);
        run(0, 2, 1'b0, 1'b1);
        run(255, 1, 1'b0, 1'b0);
        for (int r = 0; r < 6; r++) begin
            L = int'($urandom_range(0, 12));
            P = int'($urandom_range(0, 4));
            run(L, P, 1'b0, 1'b0);
        end
`ifdef LOOP_SEQ_STEP_EN
        run(2, 1, 1'b1, 1'b0);
`endif

        // Start held high re-triggers straight out of DONE.
        @(negedge clk);
        start = 1'b1; limit = 8'd1; passes = 4'd1;
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!done && waited < 40);
        check("b2b_done_seen", done, 1);
        @(negedge clk);
        check("b2b_idle_gap", busy, 0);
        @(negedge clk);
        start = 1'b0;
        check("b2b_retrigger", busy, 1);
        waited = 0;
        while (busy && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        check("b2b_second_end", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
